// File: rtl/loop_address_generator.sv
// Tile address sequencer driving an external ring counter (columns) and an internal row accumulator.
// Latency: start -> LOAD -> first beat on the following cycle; addr_o is combinational from col_idx_i in RUN.
// Backpressure: col_en_o follows ready_i, so the column counter and addr_o hold while ready_i is low.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_i, num_col_i, num_row_i, base_addr_i, stride_i : tile request, sampled in IDLE
//   col_idx_i, col_done_i : ring counter out / is_done_o
//   ready_i             : downstream accept
//   col_en_o, num_cnt_o : ring counter en / i_num_cnt
//   addr_o, addr_valid_o, row_idx_o : address beat and current row
//   busy_o, done_o      : controller status
//   row_last_o, tile_last_o : present only when LOOP_LAST_EN is defined
module loop_address_generator #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  num_col_i,
  input  logic [IDX_W-1:0]  num_row_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [IDX_W-1:0]  stride_i,
  input  logic [IDX_W-1:0]  col_idx_i,
  input  logic              col_done_i,
  input  logic              ready_i,
  output logic              col_en_o,
  output logic [IDX_W-1:0]  num_cnt_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  output logic [IDX_W-1:0]  row_idx_o,
  output logic              busy_o,
`ifdef LOOP_LAST_EN
  output logic              row_last_o,
  output logic              tile_last_o,
`endif
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  num_col_q, num_col_d;
  logic [IDX_W-1:0]  num_row_q, num_row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  stride_q, stride_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;
  logic              last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_col_q <= '0;
      num_row_q <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      row_q     <= '0;
      row_off_q <= '0;
    end else begin
      state_q   <= state_d;
      num_col_q <= num_col_d;
      num_row_q <= num_row_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      row_q     <= row_d;
      row_off_q <= row_off_d;
    end
  end

  assign last_row  = (row_q == num_row_q - IDX_W'(1));
  assign num_cnt_o = num_col_q;
  assign row_idx_o = row_q;

  always_comb begin
    state_d      = state_q;
    num_col_d    = num_col_q;
    num_row_d    = num_row_q;
    base_d       = base_q;
    stride_d     = stride_q;
    row_d        = row_q;
    row_off_d    = row_off_q;
    col_en_o     = 1'b0;
    addr_valid_o = 1'b0;
    addr_o       = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // A zero count would give the counter a compare value of all-ones,
          // so such a request finishes immediately without touching the config.
          if (num_col_i != '0 && num_row_i != '0) begin
            num_col_d = num_col_i;
            num_row_d = num_row_i;
            base_d    = base_addr_i;
            stride_d  = stride_i;
            row_d     = '0;
            row_off_d = '0;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // Gives the ring counter one cycle to register num_cnt_o before its compare is used.
        busy_o  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy_o       = 1'b1;
        addr_valid_o = 1'b1;
        col_en_o     = ready_i;
        addr_o       = base_q + row_off_q + ADDR_W'(col_idx_i);
        if (ready_i && col_done_i) begin
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d     = row_q + IDX_W'(1);
            row_off_d = row_off_q + ADDR_W'(stride_q);
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LOOP_LAST_EN
  assign row_last_o  = addr_valid_o & (col_idx_i == num_col_q - IDX_W'(1));
  assign tile_last_o = row_last_o & last_row;
`endif

endmodule
